// File: rtl/shift_in_frame.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit frames from a bit stream
// and hands each completed frame to a consumer over a valid/ack handshake.
module shift_in_frame #(
   parameter int unsigned WIDTH     = 12,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ena,
   input  logic                           data_in,
   input  logic                           sync,
   input  logic                           data_ack,
   output logic [WIDTH-1:0]               data_out,
   output logic                           data_valid,
   output logic [$clog2(WIDTH+1)-1:0]     bit_cnt,
   output logic                           overrun
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] shift_base, shifted;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             complete;

   always_comb begin
      // A sync with a bit starts a fresh frame, so shift into an empty register.
      shift_base = sync ? '0 : sreg_q;
      if (MSB_FIRST) begin
         shifted = {shift_base[WIDTH-2:0], data_in};
      end else begin
         shifted = {data_in, shift_base[WIDTH-1:1]};
      end
      complete = ena && !sync && (cnt_q == LastCnt);

      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (ena) begin
         sreg_d = shifted;
         if (sync) begin
            cnt_d = CntW'(1);
         end else if (complete) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (sync) begin
         sreg_d = '0;
         cnt_d  = '0;
      end

      out_d   = out_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (complete) begin
         // An ack in the completion cycle frees the holding register for the new frame.
         if (!valid_q || data_ack) begin
            out_d   = shifted;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && data_ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q  <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_out   = out_q;
   assign data_valid = valid_q;
   assign bit_cnt    = cnt_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_shift_in_frame.sv
// Self-checking bench for shift_in_frame: an MSB-first and an LSB-first instance
// share one stimulus stream; expected frames are queued and checked on delivery.
module tb_shift_in_frame;

   logic        clk;
   logic        rst;
   logic        ena;
   logic        data_in;
   logic        sync;
   logic        data_ack;
   logic [11:0] out_m, out_l;
   logic        valid_m, valid_l;
   logic [3:0]  cnt_m, cnt_l;
   logic        ovr_m, ovr_l;

   int          n_tests;
   int          n_fail;
   int          exp_cnt;
   logic [11:0] exp_q[$];

   typedef struct {
      logic [11:0] word;
      int          gap;
      logic [11:0] exp_msb;
      logic [11:0] exp_lsb;
   } vec_t;

   vec_t vecs[4];

   shift_in_frame #(.WIDTH(12), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .sync(sync),
      .data_ack(data_ack), .data_out(out_m), .data_valid(valid_m),
      .bit_cnt(cnt_m), .overrun(ovr_m)
   );

   shift_in_frame #(.WIDTH(12), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .sync(sync),
      .data_ack(data_ack), .data_out(out_l), .data_valid(valid_l),
      .bit_cnt(cnt_l), .overrun(ovr_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] rev12(input logic [11:0] w);
      logic [11:0] r;
      for (int i = 0; i < 12; i++) r[i] = w[11-i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send nbits of word, MSB of word first on the wire.
   task automatic send_bits(input logic [11:0] word, input int nbits, input int gap,
                            input bit sync_first, input bit ack_last, input bit keep);
      for (int k = 0; k < nbits; k++) begin
         ena      = 1'b1;
         data_in  = word[11-k];
         sync     = sync_first && (k == 0);
         data_ack = ack_last && (k == nbits - 1);
         if (k == nbits - 1 && nbits == 12 && keep) exp_q.push_back(word);
         tick();
         exp_cnt  = sync ? 1 : (exp_cnt + 1) % 12;
         ena      = 1'b0;
         sync     = 1'b0;
         data_ack = 1'b0;
         check("bit_cnt", 32'(cnt_m), 32'(exp_cnt));
         for (int g = 0; g < gap; g++) begin
            tick();
            check("bit_cnt_gap", 32'(cnt_m), 32'(exp_cnt));
         end
      end
   endtask

   task automatic deliver(input logic [11:0] exp_lsb_override, input bit use_override);
      logic [11:0] e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL deliver: got empty scoreboard, expected a queued frame");
      end else begin
         e = exp_q.pop_front();
         check("data_out_msb", 32'(out_m), 32'(e));
         check("data_out_lsb", 32'(out_l), use_override ? 32'(exp_lsb_override) : 32'(rev12(e)));
         check("data_valid", 32'(valid_m), 32'd1);
      end
   endtask

   task automatic ack_once();
      logic [11:0] held;
      held     = out_m;
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("valid_after_ack", 32'(valid_m), 32'd0);
      check("data_kept_after_ack", 32'(out_m), 32'(held));
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      exp_cnt  = 0;
      rst      = 1'b1;
      ena      = 1'b0;
      data_in  = 1'b0;
      sync     = 1'b0;
      data_ack = 1'b0;

      vecs[0] = '{word: 12'hA71, gap: 0, exp_msb: 12'hA71, exp_lsb: 12'h8E5};
      vecs[1] = '{word: 12'hA71, gap: 1, exp_msb: 12'hA71, exp_lsb: 12'h8E5};
      vecs[2] = '{word: 12'hA71, gap: 3, exp_msb: 12'hA71, exp_lsb: 12'h8E5};
      vecs[3] = '{word: 12'h5C3, gap: 2, exp_msb: 12'h5C3, exp_lsb: 12'hC3A};

      tick();
      tick();
      rst = 1'b0;
      check("rst_data_out", 32'(out_m), 32'd0);
      check("rst_valid", 32'(valid_m), 32'd0);
      check("rst_bit_cnt", 32'(cnt_m), 32'd0);
      check("rst_overrun", 32'(ovr_m), 32'd0);

      for (int i = 0; i < 4; i++) begin
         send_bits(vecs[i].word, 12, vecs[i].gap, 1'b0, 1'b0, 1'b1);
         check("vec_msb", 32'(out_m), 32'(vecs[i].exp_msb));
         deliver(vecs[i].exp_lsb, 1'b1);
         check("vec_overrun", 32'(ovr_m), 32'd0);
         ack_once();
      end

      // Ack while nothing is held is ignored.
      ack_once();

      // Sync without a bit discards a partial frame.
      send_bits(12'hFFF, 5, 0, 1'b0, 1'b0, 1'b1);
      sync = 1'b1;
      tick();
      sync    = 1'b0;
      exp_cnt = 0;
      check("sync_clears_cnt", 32'(cnt_m), 32'd0);
      check("sync_keeps_valid", 32'(valid_m), 32'd0);
      send_bits(12'hFFF, 12, 0, 1'b0, 1'b0, 1'b1);
      deliver(12'h0, 1'b0);
      ack_once();

      // Sync coincident with a bit: that bit starts the new frame.
      send_bits(12'hFFF, 5, 0, 1'b0, 1'b0, 1'b1);
      send_bits(12'h9AB, 12, 0, 1'b1, 1'b0, 1'b1);
      deliver(12'h0, 1'b0);
      ack_once();

      // Handshake overlap and overrun.
      send_bits(12'h123, 12, 0, 1'b0, 1'b0, 1'b1);
      deliver(12'h0, 1'b0);
      send_bits(12'h456, 12, 0, 1'b0, 1'b1, 1'b1);
      deliver(12'h0, 1'b0);
      check("overlap_no_overrun", 32'(ovr_m), 32'd0);
      send_bits(12'h789, 12, 0, 1'b0, 1'b0, 1'b0);
      check("drop_keeps_data", 32'(out_m), 32'h456);
      check("drop_keeps_valid", 32'(valid_m), 32'd1);
      check("overrun_set", 32'(ovr_m), 32'd1);
      ack_once();
      check("overrun_sticky", 32'(ovr_m), 32'd1);

      // Reset mid-frame while a frame is held.
      send_bits(12'h111, 12, 0, 1'b0, 1'b0, 1'b1);
      deliver(12'h0, 1'b0);
      send_bits(12'hABC, 7, 0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      exp_cnt = 0;
      check("mid_rst_data_msb", 32'(out_m), 32'd0);
      check("mid_rst_data_lsb", 32'(out_l), 32'd0);
      check("mid_rst_valid", 32'(valid_m), 32'd0);
      check("mid_rst_cnt", 32'(cnt_m), 32'd0);
      check("mid_rst_overrun", 32'(ovr_m), 32'd0);
      send_bits(12'h0F0, 12, 0, 1'b0, 1'b0, 1'b1);
      deliver(12'h0, 1'b0);
      check("post_rst_overrun", 32'(ovr_m), 32'd0);
      check("lsb_inst_valid", 32'(valid_l), 32'd1);
      check("lsb_inst_cnt", 32'(cnt_l), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
